// File: rtl/execute_unit.sv
// Execute stage: single-cycle INT/SHIFT/LOGIC ops, iterative shift-add multiplier,
// persistent {Z,N,C,V} flags and a registered, stallable output stage.
module execute_unit #(
  parameter int WORD    = 32,
  parameter int W_RD    = 5,
  parameter int W_OPC   = 4,
  parameter int W_FLAGS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_i,
  output logic               stall_o,
  input  logic [WORD-1:0]    src_i,
  input  logic [WORD-1:0]    dest_i,
  input  logic               wb_i,
  input  logic [W_RD-1:0]    rd_num_i,
  input  logic [2:0]         dopc_i,
  input  logic [W_OPC-1:0]   opc_i,
  input  logic               stall_i,
  output logic               v_o,
  output logic [W_RD-1:0]    rd_num_o,
  output logic               wb_o,
  output logic [WORD-1:0]    rd_data_o,
  output logic [W_FLAGS-1:0] flags_o
);
  localparam int SH_W  = $clog2(WORD);
  localparam int CNT_W = SH_W + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic                out_free;
  logic                accept;

  logic [SH_W-1:0]     sh_p0;
  logic [WORD:0]       shl_p0;
  logic [WORD:0]       shr_p0;
  logic signed [WORD:0] sra_p0;
  logic [WORD-1:0]     res_p0;
  logic                c_p0, v_p0, fw_p0, wb_ok_p0, is_mul_p0;

  logic [2*WORD-1:0]   prod_p1;
  logic [WORD-1:0]     mcand_p1;
  logic [W_RD-1:0]     rd_num_p1;
  logic                wb_p1;
  logic [WORD:0]       msum_p1;

  // Returns {carry, signed overflow, sum}; subtraction is a + ~b + 1.
  function automatic logic [WORD+1:0] addsub(input logic [WORD-1:0] a,
                                             input logic [WORD-1:0] b,
                                             input logic            sub);
    logic [WORD-1:0] bb;
    logic [WORD:0]   s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{WORD{1'b0}}, sub};
    return {s[WORD], (a[WORD-1] == bb[WORD-1]) && (s[WORD-1] != a[WORD-1]), s[WORD-1:0]};
  endfunction

  assign out_free = ~(v_o & stall_i);
  assign stall_o  = (state != IDLE) | (v_o & stall_i);
  assign accept   = v_i & ~stall_o;

  // Stage p0: combinational ALU; the extra bit on each shift catches the last bit out.
  assign sh_p0  = src_i[SH_W-1:0];
  assign shl_p0 = {1'b0, dest_i} << sh_p0;
  assign shr_p0 = {dest_i, 1'b0} >> sh_p0;
  assign sra_p0 = $signed({dest_i, 1'b0}) >>> sh_p0;

  always_comb begin
    res_p0    = '0;
    c_p0      = 1'b0;
    v_p0      = 1'b0;
    fw_p0     = 1'b0;
    wb_ok_p0  = 1'b0;
    is_mul_p0 = 1'b0;
    case (dopc_i)
      3'b100: begin
        case (opc_i)
          W_OPC'(0): begin {c_p0, v_p0, res_p0} = addsub(dest_i, src_i, 1'b0); fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(1): begin {c_p0, v_p0, res_p0} = addsub(dest_i, src_i, 1'b1); fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(2): begin {c_p0, v_p0, res_p0} = addsub(dest_i, src_i, 1'b1); fw_p0 = 1'b1; end
          W_OPC'(3): is_mul_p0 = 1'b1;
          default: ;
        endcase
      end
      3'b010: begin
        case (opc_i)
          W_OPC'(0): begin res_p0 = shl_p0[WORD-1:0]; c_p0 = shl_p0[WORD]; fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(1): begin res_p0 = shr_p0[WORD:1];   c_p0 = shr_p0[0];    fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(2): begin res_p0 = sra_p0[WORD:1];   c_p0 = sra_p0[0];    fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          default: ;
        endcase
      end
      3'b001: begin
        case (opc_i)
          W_OPC'(0): begin res_p0 = dest_i & src_i; fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(1): begin res_p0 = dest_i | src_i; fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(2): begin res_p0 = dest_i ^ src_i; fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          W_OPC'(3): begin res_p0 = ~dest_i;        fw_p0 = 1'b1; wb_ok_p0 = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Stage p1: shift-add multiplier; multiplier in the low half, partial sum in the high half.
  assign msum_p1 = {1'b0, prod_p1[2*WORD-1:WORD]} + {1'b0, {WORD{prod_p1[0]}} & mcand_p1};

  always_ff @(posedge clk) begin
    if (accept && is_mul_p0) begin
      prod_p1   <= {{WORD{1'b0}}, src_i};
      mcand_p1  <= dest_i;
      rd_num_p1 <= rd_num_i;
      wb_p1     <= wb_i;
    end else if (state == MUL) begin
      prod_p1 <= {msum_p1, prod_p1[WORD-1:1]};
    end
  end

  // Stage p2: FSM and the registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      v_o       <= 1'b0;
      wb_o      <= 1'b0;
      rd_num_o  <= '0;
      rd_data_o <= '0;
      flags_o   <= '0;
    end else begin
      case (state)
        IDLE: if (accept && is_mul_p0) begin
          state <= MUL;
          cnt   <= CNT_W'(WORD);
        end
        MUL: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= DONE;
        end
        DONE: if (out_free) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (out_free) begin
        if (state == DONE) begin
          v_o       <= 1'b1;
          wb_o      <= wb_p1;
          rd_num_o  <= rd_num_p1;
          rd_data_o <= prod_p1[WORD-1:0];
          flags_o   <= {prod_p1[WORD-1:0] == '0, prod_p1[WORD-1], |prod_p1[2*WORD-1:WORD], 1'b0};
        end else if (accept && !is_mul_p0) begin
          v_o       <= 1'b1;
          wb_o      <= wb_i & wb_ok_p0;
          rd_num_o  <= rd_num_i;
          rd_data_o <= res_p0;
          if (fw_p0) flags_o <= {res_p0 == '0, res_p0[WORD-1], c_p0, v_p0};
        end else begin
          v_o  <= 1'b0;
          wb_o <= 1'b0;
        end
      end
    end
  end
endmodule
